// File: rtl/regfile_pkg.sv
// Shared types and default constants for the parametrised register file with clear sequencer.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR,
    RF_IDLE
  } rf_state_e;

  localparam int unsigned RF_XLEN      = 64;
  localparam int unsigned RF_NREGS     = 32;
  localparam int unsigned RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks clr_ptr from 1 to NREGS-1 after reset or on clear_req, holding busy high.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          idle,
  output logic          busy
);

  localparam logic [AW-1:0] LastAddr  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FirstAddr = AW'(1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      ptr_q   <= FirstAddr;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    idle     = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LastAddr) begin
          state_d = RF_IDLE;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + FirstAddr;
        end
      end
      RF_IDLE: begin
        idle = 1'b1;
        if (clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = FirstAddr;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        ptr_d   = FirstAddr;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_nrp_clr.sv
// 1W/2R register file, x0 hardwired to zero, registered reads, hardware clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_nrp_clr
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_req,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [XLEN-1:0] dout_a,
  output logic [XLEN-1:0] dout_b,
  output logic            busy
);

  localparam logic [AW-1:0] ZeroAddr = AW'(RF_ZERO_ADDR);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            idle;

  logic            ext_we;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] rd_a, rd_b;
  logic [XLEN-1:0] dout_a_q, dout_b_q;

  // Entry 0 is never written nor read; it only keeps indexing in range.
  logic [XLEN-1:0] mem [NREGS];

  regfile_clear_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .idle      (idle),
    .busy      (busy)
  );

  // A clear request wins over a write presented in the same cycle.
  assign ext_we    = idle && !clear_req && we && (waddr != ZeroAddr);
  assign mem_we    = rst_n && (clr_we || ext_we);
  assign mem_waddr = clr_we ? clr_addr : waddr;
  assign mem_wdata = clr_we ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
`ifdef REGFILE_BYPASS_EN
    if (ra != ZeroAddr) rd_a = (ext_we && waddr == ra) ? wdata : mem[ra];
    if (rb != ZeroAddr) rd_b = (ext_we && waddr == rb) ? wdata : mem[rb];
`else
    if (ra != ZeroAddr) rd_a = mem[ra];
    if (rb != ZeroAddr) rd_b = mem[rb];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !idle || clear_req) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else if (re) begin
      dout_a_q <= rd_a;
      dout_b_q <= rd_b;
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: tb/tb_regfile_nrp_clr.sv
// Directed self-checking bench for regfile_nrp_clr (default 32 x 64).
module tb_regfile_nrp_clr;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear_req;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            re;
  logic [AW-1:0]   ra, rb;
  logic [XLEN-1:0] dout_a, dout_b;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_nrp_clr #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (re),
    .ra        (ra),
    .rb        (rb),
    .dout_a    (dout_a),
    .dout_b    (dout_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    re = 1'b1; ra = a; rb = b;
    tick();
    re = 1'b0;
  endtask

  // Counts samples with busy high starting from the current one; dout must stay 0 meanwhile.
  task automatic count_busy(output int cnt, output int dout_bad);
    cnt = 0;
    dout_bad = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (dout_a !== '0 || dout_b !== '0) dout_bad++;
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt, bad;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL reset_dout_a: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== '0) begin n_fail++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
    rst_n = 1'b1;
    count_busy(cnt, bad);
    n_cmp++; if (cnt != 31) begin n_fail++; $display("FAIL reset_busy_len: got %0d want 31", cnt); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL reset_dout_during_clear: got %0d nonzero want 0", bad); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_end: got %b want 0", busy); end
    rd(5'd5, 5'd31);
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL reset_read_x5: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== '0) begin n_fail++; $display("FAIL reset_read_x31: got %h want 0", dout_b); end
  endtask

  task automatic test_write_read();
    wr(5'd3, 64'hDEAD_BEEF_0123_4567);
    rd(5'd3, 5'd3);
    n_cmp++; if (dout_a !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL wr_rd_a: got %h want deadbeef01234567", dout_a);
    end
    n_cmp++; if (dout_b !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL wr_rd_b: got %h want deadbeef01234567", dout_b);
    end
    // re low: outputs hold even when addresses change.
    ra = 5'd5; rb = 5'd6;
    tick();
    n_cmp++; if (dout_a !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL re_low_hold: got %h want deadbeef01234567", dout_a);
    end
  endtask

  task automatic test_x0();
    wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(5'd0, 5'd0);
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL x0_a: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== '0) begin n_fail++; $display("FAIL x0_b: got %h want 0", dout_b); end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] exp_a;
`ifdef REGFILE_BYPASS_EN
    exp_a = 64'h2222;
`else
    exp_a = 64'h1111;
`endif
    wr(5'd7, 64'h1111);
    we = 1'b1; waddr = 5'd7; wdata = 64'h2222;
    re = 1'b1; ra = 5'd7; rb = 5'd3;
    tick();
    we = 1'b0; re = 1'b0;
    n_cmp++; if (dout_a !== exp_a) begin n_fail++; $display("FAIL same_cycle_a: got %h want %h", dout_a, exp_a); end
    n_cmp++; if (dout_b !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++; $display("FAIL same_cycle_b: got %h want deadbeef01234567", dout_b);
    end
    rd(5'd7, 5'd7);
    n_cmp++; if (dout_a !== 64'h2222) begin n_fail++; $display("FAIL same_cycle_next_a: got %h want 2222", dout_a); end
    n_cmp++; if (dout_b !== 64'h2222) begin n_fail++; $display("FAIL same_cycle_next_b: got %h want 2222", dout_b); end
  endtask

  task automatic test_clear_req();
    int cnt, bad;
    wr(5'd10, 64'hABCD);
    clear_req = 1'b1;
    we = 1'b1; waddr = 5'd11; wdata = 64'h55;
    tick();
    clear_req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_start: got %b want 1", busy); end
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL clr_dout_zero: got %h want 0", dout_a); end
    // Writes and reads offered while busy must be ignored.
    waddr = 5'd12; wdata = 64'h77; re = 1'b1; ra = 5'd7; rb = 5'd7;
    count_busy(cnt, bad);
    we = 1'b0; re = 1'b0;
    n_cmp++; if (cnt != 31) begin n_fail++; $display("FAIL clr_busy_len: got %0d want 31", cnt); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clr_dout_during_clear: got %0d nonzero want 0", bad); end
    wr(5'd13, 64'h99);
    rd(5'd13, 5'd13);
    n_cmp++; if (dout_a !== 64'h99) begin n_fail++; $display("FAIL clr_post_wr: got %h want 99", dout_a); end
    rd(5'd10, 5'd11);
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL clr_x10: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== '0) begin n_fail++; $display("FAIL clr_x11_dropped: got %h want 0", dout_b); end
    rd(5'd12, 5'd13);
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL clr_x12_busy_write: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== 64'h99) begin n_fail++; $display("FAIL clr_x13: got %h want 99", dout_b); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt, bad;
    wr(5'd20, 64'h5A);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(cnt, bad);
    n_cmp++; if (cnt != 31) begin n_fail++; $display("FAIL rst_mid_busy_len: got %0d want 31", cnt); end
    wr(5'd2, 64'h33);
    rd(5'd2, 5'd2);
    n_cmp++; if (dout_a !== 64'h33) begin n_fail++; $display("FAIL rst_mid_post_wr: got %h want 33", dout_a); end
    rd(5'd20, 5'd1);
    n_cmp++; if (dout_a !== '0) begin n_fail++; $display("FAIL rst_mid_x20: got %h want 0", dout_a); end
    n_cmp++; if (dout_b !== '0) begin n_fail++; $display("FAIL rst_mid_x1: got %h want 0", dout_b); end
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re = 1'b0; ra = '0; rb = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_clear_req();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
